// File: rtl/decode_stage_ctrl_if.sv
// decode_stage_pkg + decode_stage_ctrl_if
//
// Purpose: shared RV32I control-word types and the handshake bundle between
// the IF/ID path, the decode stage and the ID/EX register.
//
// Interface signals:
//   flush                      kill the held instruction
//   in_valid / in_ready        upstream handshake
//   in_instr [31:0]            instruction word
//   in_pc [XLEN-1:0]           instruction PC
//   out_valid / out_ready      downstream handshake
//   out_ctrl                   decoded rv32i_control_word
//   out_pc / out_instr         registered PC and word of the held instruction
//   out_md / out_illegal       held instruction is an M-op / is illegal
//   md_start / md_kill         one-cycle launch / abort pulses for mul/div
// Modports: master = pipeline side (drives inputs, consumes outputs),
//           slave  = decode stage.

package decode_stage_pkg;

  typedef enum logic [2:0] {
    alu_add = 3'b000,
    alu_sll = 3'b001,
    alu_sra = 3'b010,
    alu_sub = 3'b011,
    alu_xor = 3'b100,
    alu_srl = 3'b101,
    alu_or  = 3'b110,
    alu_and = 3'b111
  } alu_ops;

  typedef enum logic [2:0] {
    beq  = 3'b000,
    bne  = 3'b001,
    blt  = 3'b100,
    bge  = 3'b101,
    bltu = 3'b110,
    bgeu = 3'b111
  } branch_funct3_t;

  typedef enum logic [3:0] {
    alu_out  = 4'd0,
    br_en    = 4'd1,
    u_imm    = 4'd2,
    lw       = 4'd3,
    pc_plus4 = 4'd4,
    lb       = 4'd5,
    lbu      = 4'd6,
    lh       = 4'd7,
    lhu      = 4'd8
  } regfilemux_sel_t;

  typedef enum logic {
    rs1_out = 1'b0,
    pc_out  = 1'b1
  } alumux1_sel_t;

  typedef enum logic [2:0] {
    a2_i_imm   = 3'd0,
    a2_u_imm   = 3'd1,
    a2_b_imm   = 3'd2,
    a2_s_imm   = 3'd3,
    a2_j_imm   = 3'd4,
    a2_rs2_out = 3'd5
  } alumux2_sel_t;

  typedef enum logic {
    cmp_rs2_out = 1'b0,
    cmp_i_imm   = 1'b1
  } cmpmux_sel_t;

  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_IMM   = 7'b0010011;
  localparam logic [6:0] OP_REG   = 7'b0110011;

  typedef struct packed {
    logic [6:0]      opcode;
    logic [2:0]      funct3;
    logic [6:0]      funct7;
    alu_ops          aluop;
    branch_funct3_t  cmpop;
    logic            load_regfile;
    regfilemux_sel_t regfilemux_sel;
    alumux1_sel_t    alumux1_sel;
    alumux2_sel_t    alumux2_sel;
    cmpmux_sel_t     cmpmux_sel;
    logic            dmem_read;
    logic            dmem_write;
    logic [3:0]      mem_byte_enable;
    logic            br_en;
  } rv32i_control_word;

endpackage

interface decode_stage_ctrl_if #(
  parameter int XLEN = 32
);
  import decode_stage_pkg::*;

  logic              flush;
  logic              in_valid;
  logic              in_ready;
  logic [31:0]       in_instr;
  logic [XLEN-1:0]   in_pc;
  logic              out_valid;
  logic              out_ready;
  rv32i_control_word out_ctrl;
  logic [XLEN-1:0]   out_pc;
  logic [31:0]       out_instr;
  logic              out_md;
  logic              out_illegal;
  logic              md_start;
  logic              md_kill;

  modport master (
    output flush, in_valid, in_instr, in_pc, out_ready,
    input  in_ready, out_valid, out_ctrl, out_pc, out_instr,
           out_md, out_illegal, md_start, md_kill
  );

  modport slave (
    input  flush, in_valid, in_instr, in_pc, out_ready,
    output in_ready, out_valid, out_ctrl, out_pc, out_instr,
           out_md, out_illegal, md_start, md_kill
  );

endinterface

// File: rtl/decode_stage_ctrl.sv
// decode_stage_ctrl
//
// Purpose: registered RV32I/RV32M decode stage. Each accepted instruction is
// decoded into an rv32i_control_word and held under a valid/ready handshake.
// M-ops park the stage in WAIT for MUL_LAT/DIV_LAT cycles while the mul/div
// unit runs; flush empties the stage and aborts an in-flight M-op.
//
// Ports:
//   clk   rising-edge clock
//   rst   asynchronous, active-low reset
//   bus   decode_stage_ctrl_if.slave (handshakes, decoded outputs, md pulses)
//
// Parameters: XLEN (PC width), EN_M (decode RV32M, else illegal),
//             MUL_LAT / DIV_LAT (stage occupancy of mul / div ops, >= 1).

module decode_stage_ctrl #(
  parameter int XLEN    = 32,
  parameter int EN_M    = 1,
  parameter int MUL_LAT = 3,
  parameter int DIV_LAT = 33
) (
  input  logic                clk,
  input  logic                rst,
  decode_stage_ctrl_if.slave  bus
);
  import decode_stage_pkg::*;

  localparam int MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
  localparam int CNT_W   = $clog2(MAX_LAT) + 1;
  localparam logic [CNT_W-1:0] MUL_CNT = CNT_W'(MUL_LAT - 1);
  localparam logic [CNT_W-1:0] DIV_CNT = CNT_W'(DIV_LAT - 1);

  typedef enum logic [1:0] {EMPTY, FULL, WAIT} state_t;

  state_t            state_reg;
  logic [CNT_W-1:0]  cnt_reg;
  logic              out_valid_reg;
  rv32i_control_word ctrl_reg;
  logic [XLEN-1:0]   pc_reg;
  logic [31:0]       instr_reg;
  logic              md_reg;
  logic              illegal_reg;
  logic              md_start_reg;
  logic              md_kill_reg;

  rv32i_control_word dec_ctrl;
  logic              dec_md;
  logic              dec_illegal;
  logic [CNT_W-1:0]  dec_cnt;
  logic              in_ready_int;
  logic              capture;

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;

  assign opcode = bus.in_instr[6:0];
  assign funct3 = bus.in_instr[14:12];
  assign funct7 = bus.in_instr[31:25];

  // Combinational decode of the incoming word.
  always_comb begin
    dec_ctrl                 = '0;
    dec_ctrl.opcode          = opcode;
    dec_ctrl.funct3          = funct3;
    dec_ctrl.funct7          = funct7;
    dec_ctrl.aluop           = alu_add;
    dec_ctrl.cmpop           = beq;
    dec_ctrl.load_regfile    = 1'b0;
    dec_ctrl.regfilemux_sel  = alu_out;
    dec_ctrl.alumux1_sel     = rs1_out;
    dec_ctrl.alumux2_sel     = a2_i_imm;
    dec_ctrl.cmpmux_sel      = cmp_rs2_out;
    dec_ctrl.dmem_read       = 1'b0;
    dec_ctrl.dmem_write      = 1'b0;
    dec_ctrl.mem_byte_enable = 4'b1111;
    dec_ctrl.br_en           = 1'b0;
    dec_md                   = 1'b0;
    dec_illegal              = 1'b0;

    case (opcode)
      OP_LUI: begin
        dec_ctrl.load_regfile   = 1'b1;
        dec_ctrl.regfilemux_sel = u_imm;
      end
      OP_AUIPC: begin
        dec_ctrl.alumux1_sel  = pc_out;
        dec_ctrl.alumux2_sel  = a2_u_imm;
        dec_ctrl.load_regfile = 1'b1;
      end
      OP_JAL: begin
        dec_ctrl.alumux1_sel    = pc_out;
        dec_ctrl.alumux2_sel    = a2_j_imm;
        dec_ctrl.load_regfile   = 1'b1;
        dec_ctrl.regfilemux_sel = pc_plus4;
      end
      OP_JALR: begin
        dec_ctrl.load_regfile   = 1'b1;
        dec_ctrl.regfilemux_sel = pc_plus4;
      end
      OP_BR: begin
        dec_ctrl.alumux1_sel = pc_out;
        dec_ctrl.alumux2_sel = a2_b_imm;
        dec_ctrl.cmpop       = branch_funct3_t'(funct3);
      end
      OP_LOAD: begin
        dec_ctrl.dmem_read    = 1'b1;
        dec_ctrl.load_regfile = 1'b1;
        case (funct3)
          3'b000:  dec_ctrl.regfilemux_sel = lb;
          3'b001:  dec_ctrl.regfilemux_sel = lh;
          3'b100:  dec_ctrl.regfilemux_sel = lbu;
          3'b101:  dec_ctrl.regfilemux_sel = lhu;
          default: dec_ctrl.regfilemux_sel = lw;
        endcase
      end
      OP_STORE: begin
        dec_ctrl.alumux2_sel = a2_s_imm;
        dec_ctrl.dmem_write  = 1'b1;
      end
      OP_IMM: begin
        dec_ctrl.load_regfile = 1'b1;
        case (funct3)
          3'b010: begin
            dec_ctrl.cmpmux_sel     = cmp_i_imm;
            dec_ctrl.cmpop          = blt;
            dec_ctrl.regfilemux_sel = br_en;
          end
          3'b011: begin
            dec_ctrl.cmpmux_sel     = cmp_i_imm;
            dec_ctrl.cmpop          = bltu;
            dec_ctrl.regfilemux_sel = br_en;
          end
          3'b101:  dec_ctrl.aluop = funct7[5] ? alu_sra : alu_srl;
          default: dec_ctrl.aluop = alu_ops'(funct3);
        endcase
      end
      OP_REG: begin
        if (funct7 == 7'd1) begin
          if (EN_M != 0) begin
            // M-op: result comes back through the ALU output path.
            dec_md                  = 1'b1;
            dec_ctrl.load_regfile   = 1'b1;
            dec_ctrl.regfilemux_sel = alu_out;
          end else begin
            dec_illegal = 1'b1;
          end
        end else begin
          dec_ctrl.load_regfile = 1'b1;
          dec_ctrl.alumux2_sel  = a2_rs2_out;
          case (funct3)
            3'b000:  dec_ctrl.aluop = funct7[5] ? alu_sub : alu_add;
            3'b010: begin
              dec_ctrl.cmpop          = blt;
              dec_ctrl.regfilemux_sel = br_en;
            end
            3'b011: begin
              dec_ctrl.cmpop          = bltu;
              dec_ctrl.regfilemux_sel = br_en;
            end
            3'b101:  dec_ctrl.aluop = funct7[5] ? alu_sra : alu_srl;
            default: dec_ctrl.aluop = alu_ops'(funct3);
          endcase
        end
      end
      default: dec_illegal = 1'b1;
    endcase
  end

  assign dec_cnt = funct3[2] ? DIV_CNT : MUL_CNT;

  // Intake is closed during flush and while reset is held so nothing can be
  // accepted on an edge that is about to be discarded.
  always_comb begin
    in_ready_int = 1'b0;
    case (state_reg)
      EMPTY:   in_ready_int = 1'b1;
      FULL:    in_ready_int = bus.out_ready;
      default: in_ready_int = 1'b0;
    endcase
    if (bus.flush || !rst) begin
      in_ready_int = 1'b0;
    end
  end

  assign capture = bus.in_valid & in_ready_int;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg     <= EMPTY;
      cnt_reg       <= '0;
      out_valid_reg <= 1'b0;
      ctrl_reg      <= '0;
      pc_reg        <= '0;
      instr_reg     <= '0;
      md_reg        <= 1'b0;
      illegal_reg   <= 1'b0;
      md_start_reg  <= 1'b0;
      md_kill_reg   <= 1'b0;
    end else begin
      md_start_reg <= 1'b0;
      md_kill_reg  <= 1'b0;
      if (bus.flush) begin
        state_reg     <= EMPTY;
        cnt_reg       <= '0;
        out_valid_reg <= 1'b0;
        // Only an M-op in flight has a mul/div unit to abort.
        md_kill_reg   <= (state_reg == WAIT);
      end else begin
        case (state_reg)
          EMPTY, FULL: begin
            if (capture) begin
              ctrl_reg    <= dec_ctrl;
              pc_reg      <= bus.in_pc;
              instr_reg   <= bus.in_instr;
              md_reg      <= dec_md;
              illegal_reg <= dec_illegal;
              if (dec_md) begin
                state_reg     <= WAIT;
                cnt_reg       <= dec_cnt;
                md_start_reg  <= 1'b1;
                out_valid_reg <= 1'b0;
              end else begin
                state_reg     <= FULL;
                out_valid_reg <= 1'b1;
              end
            end else if (state_reg == FULL && bus.out_ready) begin
              state_reg     <= EMPTY;
              out_valid_reg <= 1'b0;
            end
          end
          WAIT: begin
            if (cnt_reg == '0) begin
              state_reg     <= FULL;
              out_valid_reg <= 1'b1;
            end else begin
              cnt_reg <= cnt_reg - CNT_W'(1);
            end
          end
          default: begin
            state_reg     <= EMPTY;
            out_valid_reg <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.in_ready    = in_ready_int;
  assign bus.out_valid   = out_valid_reg;
  assign bus.out_ctrl    = ctrl_reg;
  assign bus.out_pc      = pc_reg;
  assign bus.out_instr   = instr_reg;
  assign bus.out_md      = md_reg;
  assign bus.out_illegal = illegal_reg;
  assign bus.md_start    = md_start_reg;
  assign bus.md_kill     = md_kill_reg;

endmodule
